program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 10, target instruction-memory word-address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, max RUN cycles before timeout.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  host byte stream data.
REQ-006 rx_valid  input  1  rx_data valid; a byte transfers when rx_valid and rx_ready are both high at a rising edge.
REQ-007 rx_ready  output  1  loader can accept a byte.
REQ-008 tgt_reset  output  1  reset to the target core/memory harness.
REQ-009 inst  output  32  instruction word being programmed.
REQ-010 inst_mem_offset  output  ADDR_W  word index of inst.
REQ-011 programming_data_valid  output  1  one-cycle write strobe for inst/inst_mem_offset.
REQ-012 programming_done  output  1  one-cycle pulse after the last word.
REQ-013 result_valid  input  1  target reports a test result this cycle.
REQ-014 result_passed  input  1  test verdict, sampled only with result_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 finished, passed, timed_out, hdr_error  output  1 each  sticky status flags.

Function
REQ-017 States SHALL be IDLE, HDR1, TRST, LOAD, WRITE, DONE, RUN.
REQ-018 Frame format SHALL be: 2-byte little-endian word count N, then 4N bytes, each word little-endian (first byte -> inst[7:0]).
REQ-019 rx_ready SHALL be high only in IDLE, HDR1 and LOAD; low in all other states.
REQ-020 IDLE: accepted byte -> count[7:0], clear all four status flags, go HDR1.
REQ-021 HDR1: accepted byte -> count[15:8]; if N==0 or N>2^ADDR_W, set hdr_error and return to IDLE (no target reset); else go TRST.
REQ-022 TRST: tgt_reset high for exactly 2 cycles, word index and byte counter cleared, then LOAD.
REQ-023 tgt_reset SHALL also be high from reset deassertion until the first valid header, and low in LOAD, WRITE, DONE, RUN.
REQ-024 LOAD: accepted bytes fill the word buffer lanes 0..3; after the 4th accepted byte go WRITE next cycle.
REQ-025 WRITE: programming_data_valid high for exactly one cycle, inst = assembled word, inst_mem_offset = word index (0 for first word); index increments after the strobe.
REQ-026 After WRITE, if index reached N go DONE, else LOAD; rx_valid gaps of any length SHALL only stall, never corrupt.
REQ-027 DONE: programming_done high exactly one cycle, RUN counter cleared, then RUN.
REQ-028 inst/inst_mem_offset SHALL hold their values outside WRITE; programming_* strobes SHALL never assert outside WRITE/DONE.
REQ-029 RUN: counter increments each cycle; result_valid -> finished=1, passed=result_passed, go IDLE.
REQ-030 RUN: counter reaching TIMEOUT_CYCLES-1 without result_valid -> finished=1, timed_out=1, passed=0, go IDLE.
REQ-031 result_valid on the same cycle as timeout SHALL win (result reported, timed_out=0).
REQ-032 result_valid outside RUN SHALL be ignored.
REQ-033 Status flags SHALL hold until the next accepted header byte in IDLE.

Reset
REQ-034 Asynchronous reset SHALL force IDLE, tgt_reset=1, rx_ready=1, inst=0, inst_mem_offset=0, programming_data_valid=0, programming_done=0, busy=0, all status flags 0, counters 0.
REQ-035 Reset mid-frame or mid-RUN SHALL abandon the frame; no partial strobe may follow reset deassertion.

Verification
REQ-036 Bytes 02 00 13 00 00 00 93 00 10 00 -> tgt_reset 2 cycles, strobes (0,0x00000013),(1,0x00100093), one programming_done pulse.
REQ-037 Header 00 00 -> hdr_error=1, no tgt_reset pulse, no strobes; header 01 04 (N=1025) -> hdr_error=1.
REQ-038 1-word load, result_valid=1 result_passed=1 on RUN cycle 10 -> finished=1, passed=1, busy=0.
REQ-039 TIMEOUT_CYCLES=16, no result -> finished=1, timed_out=1 after 16 RUN cycles; result_valid on cycle 16 -> passed per result_passed, timed_out=0.
REQ-040 Random rx_valid gaps over 1024-word frame -> offsets 0..1023 in order, data matches, last offset 1023.
REQ-041 Assert reset after 2nd byte of a word -> all outputs at reset values; new frame loads correctly.

Source files
------------

// File: rtl/program_loader_if.sv
// Host-side bus of the program loader: the byte stream from the host, the
// instruction-memory write port towards the target, and the target's
// test-result report.
//
// Handshake: a byte moves from host to loader on a rising clk edge where
// rx_valid and rx_ready are both high. The host holds rx_data stable while
// rx_valid is high and rx_ready is low; rx_ready never depends on rx_valid
// within a cycle, and rx_valid may drop between bytes for any number of cycles.
interface program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_mem_offset;
  logic              programming_data_valid;
  logic              programming_done;
  logic              result_valid;
  logic              result_passed;

  // Host / target harness side.
  modport master (
    output rx_data, rx_valid, result_valid, result_passed,
    input  rx_ready, inst, inst_mem_offset, programming_data_valid, programming_done
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid, result_valid, result_passed,
    output rx_ready, inst, inst_mem_offset, programming_data_valid, programming_done
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a framed program over a byte stream (16-bit LE word
// count, then little-endian 32-bit words), resets the target, writes each word
// into instruction memory with a one-cycle strobe, then watches the target for
// a pass/fail report or a timeout. Status flags stay sticky until the next
// frame header byte is accepted.
module program_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  program_loader_if.slave    bus,
  output logic               tgt_reset,
  output logic               busy,
  output logic               finished,
  output logic               passed,
  output logic               timed_out,
  output logic               hdr_error,
  output logic [2:0]         dbg_state
);

  localparam int                CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W + 1)'(1);
  localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR1  = 3'd1,
    TRST  = 3'd2,
    LOAD  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    RUN   = 3'd6
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [15:0]       count_q;   // word count N from the header
  logic [ADDR_W:0]   idx_q;     // next word index; one bit wider so N = 2^ADDR_W fits
  logic [1:0]        byte_q;    // byte lane in LOAD, cycle counter in TRST
  logic [23:0]       lanes_q;   // lanes 0..2 of the word being assembled
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] offset_q;
  logic [CNT_W-1:0]  run_q;
  logic              hold_q;    // target held in reset until the first valid header

  logic              accept;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic              last_word;
  logic              run_end;

  assign accept    = bus.rx_valid & bus.rx_ready;
  assign hdr_n     = {bus.rx_data, count_q[7:0]};
  assign hdr_bad   = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_WORDS);
  assign last_word = ((17'(idx_q) + 17'd1) == {1'b0, count_q});
  assign run_end   = (run_q == RUN_LAST);

  assign bus.rx_ready               = (state == IDLE) || (state == HDR1) || (state == LOAD);
  assign bus.inst                   = inst_q;
  assign bus.inst_mem_offset        = offset_q;
  assign bus.programming_data_valid = (state == WRITE);
  assign bus.programming_done       = (state == DONE);
  assign tgt_reset                  = hold_q || (state == TRST);
  assign busy                       = (state != IDLE);
  assign dbg_state                  = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a result on the timeout cycle still counts as a result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = HDR1;
      HDR1:    if (accept) state_next = hdr_bad ? IDLE : TRST;
      TRST:    if (byte_q == 2'd1) state_next = LOAD;
      LOAD:    if (accept && (byte_q == 2'd3)) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : LOAD;
      DONE:    state_next = RUN;
      RUN:     if (bus.result_valid || run_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, indices, run counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      lanes_q   <= '0;
      inst_q    <= '0;
      offset_q  <= '0;
      run_q     <= '0;
      hold_q    <= 1'b1;
      finished  <= 1'b0;
      passed    <= 1'b0;
      timed_out <= 1'b0;
      hdr_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count_q[7:0] <= bus.rx_data;
            finished     <= 1'b0;
            passed       <= 1'b0;
            timed_out    <= 1'b0;
            hdr_error    <= 1'b0;
          end
        end
        HDR1: begin
          if (accept) begin
            count_q[15:8] <= bus.rx_data;
            byte_q        <= 2'd0;
            if (hdr_bad) hdr_error <= 1'b1;
            else         hold_q    <= 1'b0;
          end
        end
        TRST: begin
          idx_q  <= '0;
          byte_q <= (byte_q == 2'd1) ? 2'd0 : (byte_q + 2'd1);
        end
        LOAD: begin
          if (accept) begin
            case (byte_q)
              2'd0:    lanes_q[7:0]   <= bus.rx_data;
              2'd1:    lanes_q[15:8]  <= bus.rx_data;
              2'd2:    lanes_q[23:16] <= bus.rx_data;
              default: begin
                inst_q   <= {bus.rx_data, lanes_q};
                offset_q <= idx_q[ADDR_W-1:0];
              end
            endcase
            byte_q <= byte_q + 2'd1;
          end
        end
        WRITE: idx_q <= idx_q + IDX_ONE;
        DONE:  run_q <= '0;
        RUN: begin
          run_q <= run_q + RUN_ONE;
          if (bus.result_valid) begin
            finished <= 1'b1;
            passed   <= bus.result_passed;
          end else if (run_end) begin
            finished  <= 1'b1;
            timed_out <= 1'b1;
            passed    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
